ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: data width, matching the dual-port RAM.
REQ-003 Parameter ADDR_WIDTH, default 8: address width, matching the 256-deep RAM.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port req  input  NREQ: per-requester request, held high until granted.
REQ-007 Port req_we  input  NREQ: per-requester write enable (1 = write, 0 = read).
REQ-008 Port req_addr  input  NREQ*ADDR_WIDTH: packed addresses; requester i at slice i.
REQ-009 Port req_wdata  input  NREQ*DATA_WIDTH: packed write data; requester i at slice i.
REQ-010 Port gnt  output  NREQ: combinational grant; transfer accepted in the cycle req[i] and gnt[i] are both 1.
REQ-011 Port rvalid  output  NREQ: registered; high one cycle after an accepted read.
REQ-012 Port rdata  output  NREQ*DATA_WIDTH: registered read data, valid while rvalid[i] is 1.
REQ-013 Ports ram_addr_a, ram_addr_b  output  ADDR_WIDTH: RAM port A/B address.
REQ-014 Ports ram_din_a, ram_din_b  output  DATA_WIDTH: RAM port A/B write data.
REQ-015 Ports ram_we_a, ram_we_b  output  1: RAM port A/B write enable.
REQ-016 Ports ram_dout_a, ram_dout_b  input  DATA_WIDTH: RAM combinational read data.

Function
REQ-017 State: round-robin pointer rr_ptr (0..NREQ-1).
REQ-018 State: rvalid register and rdata register per requester.
REQ-019 Each cycle, scan requesters in order rr_ptr, rr_ptr+1, ... mod NREQ; the first requester with req=1 gets port A.
REQ-020 Continue the scan; the next requester with req=1 that does not conflict with the port-A grant gets port B.
REQ-021 Conflict: same address and at least one of the two is a write. Two reads to the same address do not conflict.
REQ-022 At most 2 grants per cycle; gnt is one-hot or two-hot; gnt[i]=0 whenever req[i]=0.
REQ-023 Ungranted requesters keep req asserted; the arbiter holds no per-request state for them.
REQ-024 A port with no grant drives we=0, addr=0 and din=0.
REQ-025 A granted write drives the RAM port we=1 with that requester's addr and wdata; the RAM updates on the same edge.
REQ-026 A granted read drives we=0; on the next edge, rdata[i] captures the RAM dout of that port and rvalid[i] is set to 1.
REQ-027 Read latency: exactly 1 cycle. rvalid[i] is cleared in any cycle following a cycle with no accepted read for i.
REQ-028 Back-to-back reads by one requester produce rvalid high on consecutive cycles.
REQ-029 Pointer update: if any grant occurred, rr_ptr becomes (index of the last granted requester + 1) mod NREQ; otherwise it is unchanged.
REQ-030 Fairness: a continuously requesting requester is granted within NREQ cycles.
REQ-031 gnt, ram_we_a and ram_we_b are forced to 0 while rst_n=0.

Reset
REQ-032 Asserting rst_n low immediately sets rr_ptr=0, rvalid=0 and rdata=0, with no clock required.
REQ-033 A read accepted in the cycle before a mid-operation reset produces no rvalid after reset release.
REQ-034 The first cycle after reset release arbitrates normally, starting the scan at requester 0.

Verification
REQ-035 Reset: rst_n=0 with all req=1 -> gnt=000, ram_we_a=ram_we_b=0, rvalid=000, rdata=0.
REQ-036 Dual grant: rr_ptr=0; req0 writes 0x55 to addr 0x10; req1 reads addr 0x20, which holds 0xAA.
- Response: gnt=011; port A writes; next cycle rvalid[1]=1, rdata1=0xAA; rr_ptr=2.
REQ-037 Conflict: req0 writes addr 0x40 and req1 reads addr 0x40 in the same cycle.
- Response: gnt=001.
- Next cycle: req1 is granted and returns the new data, with rvalid[1]=1 one cycle later.
REQ-038 Read-read same address: req0, req1 and req2 all read addr 0x05, rr_ptr=2.
- Response: gnt=101 (req2 on port A, req0 on port B); rr_ptr becomes 1.
- Next cycle: req1 is granted.
REQ-039 Fairness: all three requesters hold req=1 with distinct addresses for 6 cycles.
- Response: each requester is granted 4 times; no requester waits more than 3 cycles.
REQ-040 Mid-operation reset: accept a read from req2, then pulse rst_n low before the next edge.
- Response: rvalid[2] stays 0 and rr_ptr=0 after release.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester-side request/grant/read-return bundle for ram_arbiter
interface ram_arbiter_if #(
    parameter int NREQ       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            req_we;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rvalid;
    logic [NREQ*DATA_WIDTH-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter mapping NREQ requesters onto a dual-port RAM
module ram_arbiter #(
    parameter int NREQ       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           rr_next;
    logic [NREQ-1:0]            gnt_a;
    logic [NREQ-1:0]            gnt_b;
    logic [NREQ-1:0]            rd_a;
    logic [NREQ-1:0]            rd_b;
    logic [NREQ-1:0]            rvalid_q;
    logic [NREQ*DATA_WIDTH-1:0] rdata_q;

    // Scan from rr_ptr: first requester takes port A, first non-conflicting one after it takes port B.
    always_comb begin
        int                    idx;
        int                    last;
        logic                  a_found;
        logic                  a_we;
        logic [ADDR_WIDTH-1:0] a_addr;
        gnt_a   = '0;
        gnt_b   = '0;
        a_found = 1'b0;
        a_we    = 1'b0;
        a_addr  = '0;
        idx     = 0;
        last    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (rst_n && bus.req[idx]) begin
                if (!a_found) begin
                    a_found    = 1'b1;
                    gnt_a[idx] = 1'b1;
                    a_we       = bus.req_we[idx];
                    a_addr     = bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                    last       = idx;
                end else if (gnt_b == '0 &&
                             !(bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] == a_addr &&
                               (a_we || bus.req_we[idx]))) begin
                    gnt_b[idx] = 1'b1;
                    last       = idx;
                end
            end
        end
        rr_next = rr_ptr;
        if (a_found) rr_next = (last == NREQ - 1) ? '0 : PTR_W'(last + 1);
    end

    always_comb begin
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_din_a  = '0;
        ram_din_b  = '0;
        ram_we_a   = |(gnt_a & bus.req_we);
        ram_we_b   = |(gnt_b & bus.req_we);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_a[i]) begin
                ram_addr_a = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (bus.req_we[i]) ram_din_a = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (gnt_b[i]) begin
                ram_addr_b = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (bus.req_we[i]) ram_din_b = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_a       = gnt_a & ~bus.req_we;
    assign rd_b       = gnt_b & ~bus.req_we;
    assign bus.gnt    = gnt_a | gnt_b;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr   <= rr_next;
            rvalid_q <= rd_a | rd_b;
            for (int i = 0; i < NREQ; i++) begin
                if (rd_a[i])      rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_a;
                else if (rd_b[i]) rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_b;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a reference model
module tb_ram_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int AW   = 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic          ram_we_a, ram_we_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
    logic [DW-1:0] mem [256];

    ram_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_dout_a = mem[ram_addr_a];
    assign ram_dout_b = mem[ram_addr_b];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    end

    int n_total = 0;
    int n_bad   = 0;

    logic          r_req   [NREQ];
    logic          r_we    [NREQ];
    logic [AW-1:0] r_addr  [NREQ];
    logic [DW-1:0] r_wdata [NREQ];

    logic [DW-1:0]      ref_mem [256];
    int                 m_ptr;
    logic [NREQ-1:0]    exp_rvalid;
    logic [NREQ*DW-1:0] exp_rdata;
    logic [NREQ-1:0]    dut_gnt;
    logic [NREQ-1:0]    dut_rvalid;
    logic [NREQ*DW-1:0] dut_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                 = r_req[i];
            bus.req_we[i]              = r_we[i];
            bus.req_addr[i*AW +: AW]   = r_addr[i];
            bus.req_wdata[i*DW +: DW]  = r_wdata[i];
        end
    endtask

    // Reference arbitration: list pending requesters in round-robin order, pick first and first compatible.
    function automatic void model_arb(output int a, output int b);
        int cand[$];
        a = -1;
        b = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (r_req[i]) cand.push_back(i);
        end
        if (cand.size() > 0) begin
            a = cand[0];
            for (int j = 1; j < cand.size(); j++) begin
                if (!(r_addr[cand[j]] == r_addr[a] && (r_we[a] || r_we[cand[j]]))) begin
                    b = cand[j];
                    break;
                end
            end
        end
    endfunction

    task automatic step();
        int              a, b;
        logic [NREQ-1:0] eg;
        logic            ewa, ewb;
        logic [AW-1:0]   eaa, eab;
        drive();
        @(negedge clk);
        model_arb(a, b);
        eg = '0; ewa = 1'b0; ewb = 1'b0; eaa = '0; eab = '0;
        if (a >= 0) begin eg[a] = 1'b1; ewa = r_we[a]; eaa = r_addr[a]; end
        if (b >= 0) begin eg[b] = 1'b1; ewb = r_we[b]; eab = r_addr[b]; end
        dut_gnt    = bus.gnt;
        dut_rvalid = bus.rvalid;
        dut_rdata  = bus.rdata;
        chk("gnt", dut_gnt, eg);
        chk("rvalid", dut_rvalid, exp_rvalid);
        chk("rdata", dut_rdata, exp_rdata);
        chk("we_a", ram_we_a, ewa);
        chk("we_b", ram_we_b, ewb);
        chk("addr_a", ram_addr_a, eaa);
        chk("addr_b", ram_addr_b, eab);
        if (ewa) chk("din_a", ram_din_a, r_wdata[a]);
        if (ewb) chk("din_b", ram_din_b, r_wdata[b]);
        exp_rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i] && !r_we[i]) begin
                exp_rvalid[i]           = 1'b1;
                exp_rdata[i*DW +: DW]   = ref_mem[r_addr[i]];
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (eg[i] && r_we[i]) ref_mem[r_addr[i]] = r_wdata[i];
        if (a >= 0) m_ptr = (((b >= 0) ? b : a) + 1) % NREQ;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (eg[i]) r_req[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        r_req[i] = 1'b1; r_we[i] = we; r_addr[i] = ad; r_wdata[i] = wd;
    endtask

    initial begin
        int cnt[NREQ];
        int wt[NREQ];
        int maxw;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i) ^ 8'h5A;
            ref_mem[i] = DW'(i) ^ 8'h5A;
        end
        mem[8'h20] = 8'hAA;
        ref_mem[8'h20] = 8'hAA;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(8'h60 + i), 8'hFF);
        m_ptr = 0; exp_rvalid = '0; exp_rdata = '0;

        // Asynchronous reset with everyone requesting
        rst_n = 1'b1;
        drive();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 3'b000);
        chk("rst_we_a", ram_we_a, 1'b0);
        chk("rst_we_b", ram_we_b, 1'b0);
        chk("rst_rvalid", bus.rvalid, 3'b000);
        chk("rst_rdata", bus.rdata, 0);
        @(posedge clk);
        #1;
        chk("rst_gnt_clk", bus.gnt, 3'b000);
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        drive();
        rst_n = 1'b1;

        set_req(0, 1'b1, 8'h10, 8'h55);
        set_req(1, 1'b0, 8'h20, 8'h00);
        step();
        chk("dual_gnt", dut_gnt, 3'b011);

        set_req(0, 1'b1, 8'h40, 8'h3C);
        set_req(1, 1'b0, 8'h40, 8'h00);
        step();
        chk("dual_rvalid", dut_rvalid, 3'b010);
        chk("dual_rdata1", dut_rdata[15:8], 8'hAA);
        chk("conf_gnt", dut_gnt, 3'b001);
        step();
        chk("conf_gnt2", dut_gnt, 3'b010);

        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h05, 8'h00);
        step();
        chk("conf_rvalid", dut_rvalid, 3'b010);
        chk("conf_rdata1", dut_rdata[15:8], 8'h3C);
        chk("rr_gnt", dut_gnt, 3'b101);
        step();
        chk("rr_gnt2", dut_gnt, 3'b010);

        // Continuous requests: count grants and longest wait per requester
        maxw = 0;
        for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; wt[i] = 0; end
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8'h80 + i), 8'h00);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (dut_gnt[i]) begin cnt[i]++; wt[i] = 0; end
                else begin wt[i]++; if (wt[i] > maxw) maxw = wt[i]; end
            end
        end
        for (int i = 0; i < NREQ; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 4);
        chk("fair_wait", maxw <= 3, 1'b1);

        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        step();

        // Read accepted, then reset before the edge that would return it
        set_req(2, 1'b0, 8'h07, 8'h00);
        drive();
        @(negedge clk);
        chk("mid_gnt", bus.gnt, 3'b100);
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        drive();
        #1;
        chk("mid_rst_gnt", bus.gnt, 3'b000);
        chk("mid_rst_rvalid", bus.rvalid, 3'b000);
        m_ptr = 0; exp_rvalid = '0; exp_rdata = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8'h30 + i), 8'h00);
        step();
        chk("post_rst_rvalid", dut_rvalid, 3'b000);
        chk("post_rst_gnt", dut_gnt, 3'b011);
        step();

        // Randomized traffic with a narrow address window to provoke conflicts
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_req[i] && ($urandom % 4) != 0)
                    set_req(i, 1'(($urandom % 2)),
                            ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom % 256),
                            DW'($urandom));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
